gpio_irq_ctrl: RTL and testbench

Parametrised memory-mapped GPIO controller with per-bit direction, atomic set/clear/toggle of the output register, a two-flop input synchroniser, and per-bit rising/falling edge interrupt capture. It sits on the simple we/re/addr/wdata/rdata peripheral bus next to the processor core and drives a single level interrupt line to the core's interrupt input.

---
 rtl/gpio_pkg.sv | 50 +++++
 rtl/gpio_irq_ctrl_if.sv | 19 +
 rtl/gpio_sync.sv | 26 ++
 rtl/gpio_irq_ctrl.sv | 112 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt controller: default sizes,
// register byte offsets and the register decode used by the top.
package gpio_pkg;

   localparam int GPIO_WIDTH_DEF  = 32;
   localparam int GPIO_ADDR_W_DEF = 6;
   localparam int GPIO_BUS_W      = 32;

   localparam logic [GPIO_BUS_W-1:0] GPIO_DATA_OUT    = 32'h00;
   localparam logic [GPIO_BUS_W-1:0] GPIO_DIR         = 32'h04;
   localparam logic [GPIO_BUS_W-1:0] GPIO_DATA_IN     = 32'h08;
   localparam logic [GPIO_BUS_W-1:0] GPIO_OUT_SET     = 32'h0C;
   localparam logic [GPIO_BUS_W-1:0] GPIO_OUT_CLR     = 32'h10;
   localparam logic [GPIO_BUS_W-1:0] GPIO_OUT_TGL     = 32'h14;
   localparam logic [GPIO_BUS_W-1:0] GPIO_IRQ_RISE_EN = 32'h18;
   localparam logic [GPIO_BUS_W-1:0] GPIO_IRQ_FALL_EN = 32'h1C;
   localparam logic [GPIO_BUS_W-1:0] GPIO_IRQ_STATUS  = 32'h20;

   typedef enum logic [3:0] {
      REG_DATA_OUT,
      REG_DIR,
      REG_DATA_IN,
      REG_OUT_SET,
      REG_OUT_CLR,
      REG_OUT_TGL,
      REG_RISE_EN,
      REG_FALL_EN,
      REG_IRQ_STATUS,
      REG_NONE
   } gpio_reg_e;

   // Offsets must match exactly; misaligned or out-of-map addresses decode to REG_NONE.
   function automatic gpio_reg_e gpio_decode(input logic [GPIO_BUS_W-1:0] offset);
      gpio_reg_e sel;
      case (offset)
         GPIO_DATA_OUT:    sel = REG_DATA_OUT;
         GPIO_DIR:         sel = REG_DIR;
         GPIO_DATA_IN:     sel = REG_DATA_IN;
         GPIO_OUT_SET:     sel = REG_OUT_SET;
         GPIO_OUT_CLR:     sel = REG_OUT_CLR;
         GPIO_OUT_TGL:     sel = REG_OUT_TGL;
         GPIO_IRQ_RISE_EN: sel = REG_RISE_EN;
         GPIO_IRQ_FALL_EN: sel = REG_FALL_EN;
         GPIO_IRQ_STATUS:  sel = REG_IRQ_STATUS;
         default:          sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Peripheral bus between the core (master) and the GPIO controller (slave).
interface gpio_irq_ctrl_if
   import gpio_pkg::*;
#(
   parameter int ADDR_W = GPIO_ADDR_W_DEF
);

   // No stall: a write is taken at every edge with we high, a read at every
   // edge with re high; rdata is valid from that edge and holds until the next read.
   logic                  we;
   logic                  re;
   logic [ADDR_W-1:0]     addr;
   logic [GPIO_BUS_W-1:0] wdata;
   logic [GPIO_BUS_W-1:0] rdata;

   modport master (output we, output re, output addr, output wdata, input rdata);
   modport slave  (input we, input re, input addr, input wdata, output rdata);

endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= d;
         sync2 <= sync1;
      end
   end

   assign q = sync2;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO with direction, atomic set/clear/toggle and per-bit
// rising/falling edge interrupt capture onto a single level irq line.
module gpio_irq_ctrl
   import gpio_pkg::*;
#(
   parameter int WIDTH  = GPIO_WIDTH_DEF,
   parameter int ADDR_W = GPIO_ADDR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   gpio_irq_ctrl_if.slave   bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_dir,
   output logic             irq
);

   logic [WIDTH-1:0]      data_out;
   logic [WIDTH-1:0]      dir;
   logic [WIDTH-1:0]      rise_en;
   logic [WIDTH-1:0]      fall_en;
   logic [WIDTH-1:0]      irq_status;
   logic [WIDTH-1:0]      sync2;
   logic [WIDTH-1:0]      prev;
   logic [WIDTH-1:0]      rise;
   logic [WIDTH-1:0]      fall;
   logic [WIDTH-1:0]      w1c_mask;
   logic [WIDTH-1:0]      wdata_w;
   logic [GPIO_BUS_W-1:0] addr_full;
   logic [GPIO_BUS_W-1:0] rd_mux;
   logic [GPIO_BUS_W-1:0] rdata_q;
   gpio_reg_e             reg_sel;

   function automatic logic [GPIO_BUS_W-1:0] widen(input logic [WIDTH-1:0] v);
      logic [GPIO_BUS_W-1:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   gpio_sync #(.WIDTH(WIDTH)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gpio_in),
      .q     (sync2)
   );

   always_comb begin
      addr_full = '0;
      addr_full[ADDR_W-1:0] = bus.addr;
   end

   assign reg_sel = gpio_decode(addr_full);
   assign wdata_w = bus.wdata[WIDTH-1:0];

   // Output-direction bits never raise interrupts, whatever their enables say.
   assign rise = sync2 & ~prev & ~dir & rise_en;
   assign fall = ~sync2 & prev & ~dir & fall_en;

   assign w1c_mask = (bus.we && (reg_sel == REG_IRQ_STATUS)) ? wdata_w : '0;

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_DATA_OUT:   rd_mux = widen(data_out);
         REG_DIR:        rd_mux = widen(dir);
         REG_DATA_IN:    rd_mux = widen(sync2);
         REG_RISE_EN:    rd_mux = widen(rise_en);
         REG_FALL_EN:    rd_mux = widen(fall_en);
         REG_IRQ_STATUS: rd_mux = widen(irq_status);
         default:        rd_mux = '0;
      endcase
   end

   // Read mux sees register values before this edge's write, so a same-cycle
   // read returns the old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         dir        <= '0;
         rise_en    <= '0;
         fall_en    <= '0;
         irq_status <= '0;
         prev       <= '0;
         rdata_q    <= '0;
      end else begin
         prev       <= sync2;
         irq_status <= (irq_status & ~w1c_mask) | rise | fall;
         if (bus.re) begin
            rdata_q <= rd_mux;
         end
         if (bus.we) begin
            case (reg_sel)
               REG_DATA_OUT: data_out <= wdata_w;
               REG_DIR:      dir      <= wdata_w;
               REG_OUT_SET:  data_out <= data_out | wdata_w;
               REG_OUT_CLR:  data_out <= data_out & ~wdata_w;
               REG_OUT_TGL:  data_out <= data_out ^ wdata_w;
               REG_RISE_EN:  rise_en  <= wdata_w;
               REG_FALL_EN:  fall_en  <= wdata_w;
               default:      ;
            endcase
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign gpio_out  = data_out;
   assign gpio_dir  = dir;
   assign irq       = |irq_status;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed plus randomized bench for gpio_irq_ctrl against a register-level model.
module tb_gpio_irq_ctrl;

   localparam logic [5:0] A_OUT  = 6'h00;
   localparam logic [5:0] A_DIR  = 6'h04;
   localparam logic [5:0] A_IN   = 6'h08;
   localparam logic [5:0] A_SET  = 6'h0C;
   localparam logic [5:0] A_CLR  = 6'h10;
   localparam logic [5:0] A_TGL  = 6'h14;
   localparam logic [5:0] A_REN  = 6'h18;
   localparam logic [5:0] A_FEN  = 6'h1C;
   localparam logic [5:0] A_STAT = 6'h20;

   logic        clk;
   logic        reset;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_dir;
   logic        irq;

   gpio_irq_ctrl_if #(.ADDR_W(6)) bus_if ();

   gpio_irq_ctrl #(.WIDTH(32), .ADDR_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_dir (gpio_dir),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Model state; pad_hist[0] is the pad value taken at the previous edge.
   logic [31:0] m_out, m_dir, m_ren, m_fen, m_stat, m_rdata;
   logic [31:0] pad_hist[$];
   logic [31:0] exp_q[$];

   logic [5:0] addr_tab[12] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14,
                                6'h18, 6'h1C, 6'h20, 6'h24, 6'h3C, 6'h02};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0; m_rdata = '0;
      pad_hist.delete();
      repeat (3) pad_hist.push_back('0);
      exp_q.delete();
   endtask

   function automatic logic [31:0] model_read(input logic [5:0] a);
      case (a)
         A_OUT:   return m_out;
         A_DIR:   return m_dir;
         A_IN:    return pad_hist[1];
         A_REN:   return m_ren;
         A_FEN:   return m_fen;
         A_STAT:  return m_stat;
         default: return 32'h0;
      endcase
   endfunction

   // Apply one clock edge's worth of bus/pad activity to the model.
   task automatic model_edge();
      logic [31:0] now_in, before_in, rise, fall, w1c;
      now_in    = pad_hist[1];
      before_in = pad_hist[2];
      if (bus_if.re) exp_q.push_back(model_read(bus_if.addr));
      rise = now_in & ~before_in & ~m_dir & m_ren;
      fall = ~now_in & before_in & ~m_dir & m_fen;
      w1c  = '0;
      if (bus_if.we) begin
         case (bus_if.addr)
            A_OUT:   m_out = bus_if.wdata;
            A_DIR:   m_dir = bus_if.wdata;
            A_SET:   m_out = m_out | bus_if.wdata;
            A_CLR:   m_out = m_out & ~bus_if.wdata;
            A_TGL:   m_out = m_out ^ bus_if.wdata;
            A_REN:   m_ren = bus_if.wdata;
            A_FEN:   m_fen = bus_if.wdata;
            A_STAT:  w1c   = bus_if.wdata;
            default: ;
         endcase
      end
      m_stat = (m_stat & ~w1c) | rise | fall;
      pad_hist.push_front(gpio_in);
      void'(pad_hist.pop_back());
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      check("rdata", bus_if.rdata, m_rdata);
      check("gpio_out", gpio_out, m_out);
      check("gpio_dir", gpio_dir, m_dir);
      check("irq", {31'h0, irq}, {31'h0, (m_stat != 0)});
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      tick();
      bus_if.we = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] a);
      bus_if.re = 1'b1; bus_if.addr = a;
      tick();
      bus_if.re = 1'b0;
   endtask

   task automatic bus_wr_rd(input logic [5:0] a, input logic [31:0] d);
      bus_if.we = 1'b1; bus_if.re = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      tick();
      bus_if.we = 1'b0; bus_if.re = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, bus_if.rdata, 32'h0);
      check({tag, "_gpio_out"}, gpio_out, 32'h0);
      check({tag, "_gpio_dir"}, gpio_dir, 32'h0);
      check({tag, "_irq"}, {31'h0, irq}, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      gpio_in = '0;
      bus_if.we = 1'b0; bus_if.re = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // Every register reads zero out of reset.
      for (int i = 0; i < 9; i++) begin
         bus_read(addr_tab[i]);
         check("reset_read", bus_if.rdata, 32'h0);
      end

      // Atomic output register operations.
      bus_write(A_DIR, 32'hF);
      bus_write(A_OUT, 32'h5);
      check("out_write", gpio_out, 32'h5);
      bus_write(A_SET, 32'hA);
      check("out_set", gpio_out, 32'hF);
      bus_write(A_CLR, 32'h1);
      check("out_clr", gpio_out, 32'hE);
      bus_write(A_TGL, 32'h3);
      check("out_tgl", gpio_out, 32'hD);
      bus_read(A_OUT);
      check("out_read", bus_if.rdata, 32'hD);
      bus_read(A_SET);
      check("wo_read", bus_if.rdata, 32'h0);

      // Rising edges through the synchroniser.
      bus_write(A_DIR, 32'h0);
      bus_write(A_REN, 32'hA0);
      gpio_in = 32'hA0;
      bus_read(A_IN);
      check("in_e0", bus_if.rdata, 32'h0);
      bus_read(A_IN);
      check("in_e1", bus_if.rdata, 32'h0);
      check("irq_e1", {31'h0, irq}, 32'h0);
      bus_read(A_IN);
      check("in_e2", bus_if.rdata, 32'hA0);
      check("irq_e2", {31'h0, irq}, 32'h1);
      bus_read(A_STAT);
      check("stat_a0", bus_if.rdata, 32'hA0);
      bus_write(A_STAT, 32'h20);
      bus_read(A_STAT);
      check("stat_w1c", bus_if.rdata, 32'h80);
      bus_write(A_STAT, 32'h80);
      check("irq_cleared", {31'h0, irq}, 32'h0);

      // Falling edge only, and masked while the bit is an output.
      bus_write(A_FEN, 32'h1);
      gpio_in = 32'hA1;
      idle(4);
      bus_read(A_STAT);
      check("fall_on_rise", bus_if.rdata, 32'h0);
      gpio_in = 32'hA0;
      idle(3);
      check("fall_irq", {31'h0, irq}, 32'h1);
      bus_read(A_STAT);
      check("fall_stat", bus_if.rdata, 32'h1);
      bus_write(A_STAT, 32'h1);
      bus_write(A_DIR, 32'h1);
      gpio_in = 32'hA1;
      idle(4);
      gpio_in = 32'hA0;
      idle(4);
      bus_read(A_STAT);
      check("dir_masks", bus_if.rdata, 32'h0);
      bus_write(A_DIR, 32'h0);

      // Edge and W1C on the same bit in the same cycle: the set wins.
      bus_write(A_REN, 32'h8);
      gpio_in = 32'hA8;
      idle(2);
      bus_write(A_STAT, 32'h8);
      check("set_wins_irq", {31'h0, irq}, 32'h1);
      bus_read(A_STAT);
      check("set_wins", bus_if.rdata, 32'h8);
      bus_write(A_STAT, 32'h8);

      // Simultaneous read and write returns the old value.
      bus_wr_rd(A_DIR, 32'h3);
      check("rw_old", bus_if.rdata, 32'h0);
      check("rw_dir", gpio_dir, 32'h3);
      bus_write(A_DIR, 32'h0);

      // Unmapped offsets.
      bus_write(6'h24, 32'hFFFF_FFFF);
      bus_read(6'h24);
      check("unmapped", bus_if.rdata, 32'h0);

      // Asynchronous reset with pending status and a read in flight.
      bus_write(A_REN, 32'hFF);
      gpio_in = 32'h0;
      idle(4);
      bus_write(A_STAT, 32'hFFFF_FFFF);
      gpio_in = 32'hFF;
      idle(3);
      bus_read(A_STAT);
      check("stat_ff", bus_if.rdata, 32'hFF);
      bus_if.re = 1'b1; bus_if.addr = A_OUT;
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      bus_if.re = 1'b0;
      gpio_in = '0;
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_read(A_STAT);
      check("stat_after_reset", bus_if.rdata, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus_if.we    = ($urandom_range(0, 2) == 0);
         bus_if.re    = ($urandom_range(0, 1) == 1);
         bus_if.addr  = addr_tab[$urandom_range(0, 11)];
         bus_if.wdata = $urandom;
         if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
         tick();
      end
      bus_if.we = 1'b0;
      bus_if.re = 1'b0;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
